// File: rtl/mips_trace_buffer.sv
// Write-trace capture unit: snoops register-file and data-memory write ports,
// timestamps each qualifying write and queues it in a dual-push FIFO with a
// first-word-fall-through valid/ready drain and saturating drop accounting.
module mips_trace_buffer #(
  parameter  int DATA_W  = 32,
  parameter  int RADDR_W = 5,
  parameter  int MADDR_W = 6,
  parameter  int DEPTH   = 16,
  parameter  int TS_W    = 16,
  localparam int AW      = (RADDR_W > MADDR_W) ? RADDR_W : MADDR_W,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2**RADDR_W-1:0] reg_mask,
  input  logic                  reg_we,
  input  logic [RADDR_W-1:0]    reg_waddr,
  input  logic [DATA_W-1:0]     reg_wdata,
  input  logic                  mem_we,
  input  logic [MADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_kind,
  output logic [AW-1:0]         out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic [TS_W-1:0]       out_ts,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic [15:0]           overflow_cnt
);

  // Entry storage, one array per field
  logic              kind_q [DEPTH];
  logic [AW-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TS_W-1:0]   tsv_q  [DEPTH];

  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [15:0]     ovf_q, ovf_d;

  logic          pop;
  logic [CW:0]   slots;
  logic          reg_ev, mem_ev;
  logic          push_reg, push_mem;
  logic [1:0]    drops;
  logic [16:0]   ovf_sum;
  logic [PW-1:0] mem_slot;

  // Event qualification, space allocation and next-state computation.
  // The popped slot is counted as free so a full FIFO can accept a push
  // in the same cycle it drains one entry.
  always_comb begin
    pop      = (count_q != '0) && out_ready;
    slots    = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
    reg_ev   = enable && reg_we && (reg_waddr != '0) && reg_mask[reg_waddr];
    mem_ev   = enable && mem_we;
    push_reg = reg_ev && (slots != '0);
    push_mem = mem_ev && (slots > (CW+1)'(push_reg));
    drops    = 2'(reg_ev && !push_reg) + 2'(mem_ev && !push_mem);
    mem_slot = wr_q + PW'(push_reg);
    wr_d     = wr_q + PW'(push_reg) + PW'(push_mem);
    rd_d     = rd_q + PW'(pop);
    count_d  = count_q + CW'(push_reg) + CW'(push_mem) - CW'(pop);
    ts_d     = ts_q + TS_W'(1);
    ovf_sum  = {1'b0, ovf_q} + 17'(drops);
    ovf_d    = ovf_sum[16] ? '1 : ovf_sum[15:0];
  end

  // Control state: pointers, occupancy, timestamp and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ts_q    <= '0;
      ovf_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry writes: register entry takes the first free slot, memory entry the next
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_reg) begin
        kind_q[wr_q] <= 1'b0;
        addr_q[wr_q] <= AW'(reg_waddr);
        data_q[wr_q] <= reg_wdata;
        tsv_q[wr_q]  <= ts_q;
      end
      if (push_mem) begin
        kind_q[mem_slot] <= 1'b1;
        addr_q[mem_slot] <= AW'(mem_addr);
        data_q[mem_slot] <= mem_wdata;
        tsv_q[mem_slot]  <= ts_q;
      end
    end
  end

  // Head presentation, forced to zero while the FIFO is empty
  always_comb begin
    out_valid    = (count_q != '0);
    out_kind     = out_valid ? kind_q[rd_q] : 1'b0;
    out_addr     = out_valid ? addr_q[rd_q] : '0;
    out_data     = out_valid ? data_q[rd_q] : '0;
    out_ts       = out_valid ? tsv_q[rd_q]  : '0;
    count        = count_q;
    full         = (count_q == CW'(DEPTH));
    overflow_cnt = ovf_q;
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: two instances (16-bit and 4-bit timestamps)
// share one stimulus; a queue-based reference model is checked every cycle.
module tb_mips_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] reg_mask;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        out_ready;

  logic        a_valid, a_kind, a_full;
  logic [5:0]  a_addr;
  logic [31:0] a_data;
  logic [15:0] a_ts;
  logic [4:0]  a_count;
  logic [15:0] a_ovf;

  logic        b_valid, b_kind, b_full;
  logic [5:0]  b_addr;
  logic [31:0] b_data;
  logic [3:0]  b_ts;
  logic [4:0]  b_count;
  logic [15:0] b_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_trace_buffer u_a (
    .clk(clk), .rst(rst), .enable(enable), .reg_mask(reg_mask),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_kind(a_kind),
    .out_addr(a_addr), .out_data(a_data), .out_ts(a_ts),
    .count(a_count), .full(a_full), .overflow_cnt(a_ovf)
  );

  mips_trace_buffer #(.TS_W(4)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .reg_mask(reg_mask),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_kind(b_kind),
    .out_addr(b_addr), .out_data(b_data), .out_ts(b_ts),
    .count(b_count), .full(b_full), .overflow_cnt(b_ovf)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of events with an unbounded cycle counter
  typedef struct {
    bit          kind;
    int          addr;
    logic [31:0] data;
    int          ts;
  } ent_t;

  ent_t q[$];
  int   tcnt = 0;
  int   movf = 0;
  bit   mdl_init = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      tcnt     = 0;
      movf     = 0;
      mdl_init = 1;
    end else begin
      int   free;
      bit   rev, mev;
      ent_t e;
      free = DEPTH - q.size();
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        free++;
      end
      rev = enable && reg_we && reg_waddr != 0 && reg_mask[reg_waddr];
      mev = enable && mem_we;
      if (rev) begin
        if (free > 0) begin
          e.kind = 0; e.addr = int'(reg_waddr); e.data = reg_wdata; e.ts = tcnt;
          q.push_back(e);
          free--;
        end else movf++;
      end
      if (mev) begin
        if (free > 0) begin
          e.kind = 1; e.addr = int'(mem_addr); e.data = mem_wdata; e.ts = tcnt;
          q.push_back(e);
          free--;
        end else movf++;
      end
      if (movf > 65535) movf = 65535;
      tcnt++;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (mdl_init) begin
      bit          v;
      bit          ek;
      logic [5:0]  ea;
      logic [31:0] ed;
      int          et;
      v  = (q.size() != 0);
      ek = v ? q[0].kind : 1'b0;
      ea = v ? 6'(q[0].addr) : 6'd0;
      ed = v ? q[0].data : 32'd0;
      et = v ? q[0].ts : 0;
      check("a_valid", 64'(a_valid), 64'(v));
      check("a_count", 64'(a_count), 64'(q.size()));
      check("a_full",  64'(a_full),  64'(q.size() == DEPTH));
      check("a_ovf",   64'(a_ovf),   64'(movf));
      check("a_kind",  64'(a_kind),  64'(ek));
      check("a_addr",  64'(a_addr),  64'(ea));
      check("a_data",  64'(a_data),  64'(ed));
      check("a_ts",    64'(a_ts),    64'(et % 65536));
      check("b_valid", 64'(b_valid), 64'(v));
      check("b_count", 64'(b_count), 64'(q.size()));
      check("b_ovf",   64'(b_ovf),   64'(movf));
      check("b_data",  64'(b_data),  64'(ed));
      check("b_ts",    64'(b_ts),    64'(et % 16));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    reg_we = 0; mem_we = 0;
  endtask

  initial begin
    rst = 1; enable = 1; reg_mask = '1; out_ready = 0;
    reg_we = 0; reg_waddr = '0; reg_wdata = '0;
    mem_we = 0; mem_addr = '0; mem_wdata = '0;
    repeat (2) cyc();
    rst = 0;                         // cycle with ts 0
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_full",  64'(a_full),  64'd0);
    cyc(); cyc(); cyc();             // now in cycle with ts 3
    reg_we = 1; reg_waddr = 5'd16; reg_wdata = 32'h0000_1111;
    cyc();                           // ts 4
    quiet();
    check("t1_valid", 64'(a_valid), 64'd1);
    check("t1_kind",  64'(a_kind),  64'd0);
    check("t1_addr",  64'(a_addr),  64'd16);
    check("t1_data",  64'(a_data),  64'h1111);
    check("t1_ts",    64'(a_ts),    64'd3);
    check("t1_count", 64'(a_count), 64'd1);
    out_ready = 1;
    cyc();                           // ts 5, empty
    out_ready = 0;
    reg_we = 1; reg_waddr = 5'd8; reg_wdata = 32'd5;
    mem_we = 1; mem_addr = 6'd5; mem_wdata = 32'h1011;
    cyc();                           // ts 6
    quiet();
    check("t2_count", 64'(a_count), 64'd2);
    check("t2_kind0", 64'(a_kind),  64'd0);
    check("t2_addr0", 64'(a_addr),  64'd8);
    check("t2_data0", 64'(a_data),  64'd5);
    check("t2_ts0",   64'(a_ts),    64'd5);
    out_ready = 1;
    cyc();
    check("t2_kind1", 64'(a_kind),  64'd1);
    check("t2_addr1", 64'(a_addr),  64'd5);
    check("t2_data1", 64'(a_data),  64'h1011);
    check("t2_ts1",   64'(a_ts),    64'd5);
    cyc();
    check("t2_empty", 64'(a_valid), 64'd0);
    out_ready = 0;
    // Filtered writes: $zero and a masked register
    reg_we = 1; reg_waddr = 5'd0; reg_wdata = 32'hDEAD;
    cyc();
    reg_mask[9] = 1'b0; reg_waddr = 5'd9;
    cyc();
    quiet(); reg_mask = '1;
    // enable low suppresses capture
    enable = 0; reg_we = 1; reg_waddr = 5'd4; mem_we = 1;
    cyc();
    quiet(); enable = 1;
    cyc();
    check("t3_count", 64'(a_count), 64'd0);
    check("t3_ovf",   64'(a_ovf),   64'd0);
    // Fill past capacity
    for (int i = 0; i < 18; i++) begin
      reg_we = 1; reg_waddr = 5'(i + 1); reg_wdata = 32'h100 + 32'(i);
      cyc();
    end
    quiet();
    check("t4_count", 64'(a_count), 64'd16);
    check("t4_full",  64'(a_full),  64'd1);
    check("t4_ovf",   64'(a_ovf),   64'd2);
    // Full: pop and push together
    out_ready = 1; reg_we = 1; reg_waddr = 5'd20; reg_wdata = 32'hAAAA;
    cyc();
    quiet(); out_ready = 0;
    check("t4_pp_count", 64'(a_count), 64'd16);
    check("t4_pp_ovf",   64'(a_ovf),   64'd2);
    out_ready = 1;
    cyc();
    out_ready = 0;
    check("t5_count", 64'(a_count), 64'd15);
    // One slot, dual events
    reg_we = 1; reg_waddr = 5'd21; reg_wdata = 32'hBBBB;
    mem_we = 1; mem_addr = 6'd63; mem_wdata = 32'hCCCC;
    cyc();
    check("t5_dual_count", 64'(a_count), 64'd16);
    check("t5_dual_ovf",   64'(a_ovf),   64'd3);
    cyc();                           // no slots: both dropped
    quiet();
    check("t5_drop2_ovf",  64'(a_ovf),   64'd5);
    // Timestamp wrap on the 4-bit instance while streaming
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      reg_we = 1; reg_waddr = 5'(i % 31 + 1); reg_wdata = 32'h2000 + 32'(i);
      mem_we = (i % 3 == 0); mem_addr = 6'(i); mem_wdata = 32'h3000 + 32'(i);
      cyc();
    end
    quiet();
    repeat (17) cyc();
    check("t6_drained", 64'(a_count), 64'd0);
    out_ready = 0;
    // Reset with entries queued and consumer toggling
    for (int i = 0; i < 5; i++) begin
      reg_we = 1; reg_waddr = 5'(i + 1); reg_wdata = 32'(i);
      cyc();
    end
    check("t7_pre_count", 64'(a_count), 64'd5);
    rst = 1; out_ready = 1; reg_waddr = 5'd7;
    cyc();
    rst = 0; out_ready = 0;
    check("t7_count", 64'(a_count), 64'd0);
    check("t7_valid", 64'(a_valid), 64'd0);
    check("t7_ovf",   64'(a_ovf),   64'd0);
    check("t7_data",  64'(a_data),  64'd0);
    reg_we = 1; reg_waddr = 5'd3; reg_wdata = 32'hABC;
    cyc();
    quiet();
    check("t7_ts",    64'(a_ts),    64'd0);
    check("t7_data2", 64'(a_data),  64'hABC);
    check("t7_cnt2",  64'(a_count), 64'd1);
    out_ready = 1;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Parametrised write-trace capture unit for the single-cycle MIPS core. Snoops the register-file and data-memory write ports every clock, tags each committed write with a cycle timestamp, and queues it in a dual-push FIFO drained by a valid/ready consumer. It replaces per-cycle register dumps with an event log that has filtering, overflow accounting and back-pressure.

## Interface
Parameters:
- DATA_W, 32, write-data width
- RADDR_W, 5, register address width
- MADDR_W, 6, data-memory word address width (64 words)
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable; 0 = no new entries, drain continues
- reg_mask  in  2**RADDR_W  per-register capture mask; bit n = 1 traces writes to register n
- reg_we  in  1  register-file write strobe
- reg_waddr  in  RADDR_W  register write address
- reg_wdata  in  DATA_W  register write data
- mem_we  in  1  data-memory write strobe
- mem_addr  in  MADDR_W  data-memory word address
- mem_wdata  in  DATA_W  data-memory write data
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_kind  out  1  0 = register write, 1 = memory write
- out_addr  out  max(RADDR_W,MADDR_W)  address, zero-extended
- out_data  out  DATA_W  written value
- out_ts  out  TS_W  timestamp of capture cycle
- count  out  log2(DEPTH)+1  entries held
- full  out  1  count == DEPTH
- overflow_cnt  out  16  dropped-event counter, saturating

## Operation
- Reg event: reg_we & enable & reg_waddr != 0 & reg_mask[reg_waddr]. Writes to $zero are never traced.
- Mem event: mem_we & enable. No mask.
- Timestamp: free-running TS_W counter, 0 after reset, +1 every cycle, wraps at 2**TS_W-1 -> 0. Entry ts = counter value in the capture cycle.
- FIFO: circular buffer, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH; count tracked separately.
- Up to two pushes per cycle. Order when both fire: reg entry at wr_ptr, mem entry at wr_ptr+1.
- Pop: out_valid & out_ready; rd_ptr advances by 1.
- Available slots this cycle = DEPTH - count + pop. Pop frees its slot for same-cycle pushes.
- Insufficient space: if slots = 1 and both events fire, reg entry stored, mem entry dropped. If slots = 0, all events dropped. Each dropped event adds 1 to overflow_cnt; saturates at 0xFFFF. Two drops in one cycle add 2, clamped.
- count_next = count + pushes - pop.
- Head outputs are first-word-fall-through: out_* reflect the entry at rd_ptr whenever out_valid = 1. They are don't-care when out_valid = 0 and are driven to 0 in that case.
- enable low: no events, no overflow increments. Timestamp keeps running and draining is unaffected.

## Timing
- Reset (rst high at a rising edge): pointers, count, timestamp and overflow_cnt go to 0. out_valid = 0, out_kind/out_addr/out_data/out_ts = 0, full = 0. Stored entries are discarded, and a write in the reset cycle is not captured.
- Reset mid-drain or mid-overflow: same result. Reset has priority over push and pop.
- Capture latency: an event in cycle N is visible at the head no earlier than cycle N+1. If the FIFO was empty, out_valid rises in N+1 with out_ts = N's counter value.
- Handshake: out_* stay stable while out_valid & !out_ready. A pop in cycle N presents the next entry in N+1.
- Full with a simultaneous pop and a single push: accepted, no drop, count unchanged.
- Empty with push and out_ready high: no same-cycle bypass. The entry appears in the next cycle.

## Test plan
- Reset, then reg_we=1, waddr=16, wdata=0x00001111, mask all ones, ts=3 -> next cycle out_valid=1, kind=0, addr=16, data=0x1111, ts=3, count=1.
- Same cycle: reg write r8=5 and mem write addr 5=0x1011 -> two entries in order reg then mem with equal ts; count=2; pops return r8 first.
- Write to $zero, and r9 with reg_mask[9]=0 -> no entries, overflow_cnt=0.
- DEPTH=16, out_ready=0, 18 reg writes -> count=16, full=1, overflow_cnt=2. Then with full, a pop plus a push in the same cycle -> count stays 16 and overflow_cnt stays 2.
- One free slot with dual events -> reg entry stored, overflow_cnt +1. Then TS_W=4 running 20 cycles -> ts wraps 15 -> 0 in captured entries.
- Reset asserted with 5 entries queued and out_ready toggling -> next cycle count=0, out_valid=0, overflow_cnt=0, ts restarts at 0.
